seq_mult16: RTL and testbench

- Iterative unsigned shift-add multiplier that sits directly upstream of the 32-bit datapath register.
- Accepts two WIDTH-bit operands on a start pulse and computes one product bit-step per cycle.
- Presents a held 2*WIDTH-bit product with a one-cycle done strobe, which the downstream register uses as its load/capture qualifier.

---
 rtl/seq_mult16_pkg.sv | 17 +
 rtl/seq_mult16.sv | 120 ++++++++++++
 tb/tb_seq_mult16.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult16_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult16_pkg
// Shared definitions for the iterative shift-add multiplier:
//   - FSM state encoding (IDLE / RUN)
//   - default operand width MULT_W and derived product width PROD_W
// -----------------------------------------------------------------------------
package seq_mult16_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int MULT_W = 16;
  localparam int PROD_W = 2 * MULT_W;

endpackage : seq_mult16_pkg

// File: rtl/seq_mult16.sv
// -----------------------------------------------------------------------------
// seq_mult16
// Iterative unsigned shift-add multiplier. One product bit is processed per
// clock. The result is available WIDTH cycles after the accepting start edge,
// held on product and flagged by a one-cycle done strobe that the downstream
// register uses as its capture qualifier.
//
// Ports:
//   clk      in   1        system clock, rising edge
//   rst      in   1        synchronous active-high reset, highest priority
//   start    in   1        multiply request, honoured only when idle
//   a        in   WIDTH    multiplicand (unsigned), sampled on accepted start
//   b        in   WIDTH    multiplier (unsigned), sampled on accepted start
//   busy     out  1        high while iterating
//   done     out  1        one-cycle pulse, product has just been updated
//   product  out  2*WIDTH  last completed result, held between completions
// -----------------------------------------------------------------------------
module seq_mult16
  import seq_mult16_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_mcand;
  logic [WIDTH-1:0]  r_mplr;
  logic [PW-1:0]     r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [PW-1:0]     r_product;
  logic              r_done;

  logic              w_accept;
  logic              w_last;
  logic [PW-1:0]     w_addend;
  logic [PW-1:0]     w_acc_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The final product must include the addend of the last step, so the
  // completion edge captures the sum rather than the registered accumulator.
  assign w_addend  = r_mplr[0] ? r_mcand : '0;
  assign w_acc_nxt = r_acc + w_addend;

  // Shift-add datapath, counter and completion strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mcand <= {{WIDTH{1'b0}}, a};
        r_mplr  <= b;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_product <= w_acc_nxt;
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign busy    = (r_state == ST_RUN);
  assign done    = r_done;
  assign product = r_product;

endmodule : seq_mult16

// File: tb/tb_seq_mult16.sv
// -----------------------------------------------------------------------------
// tb_seq_mult16
// Self-checking bench for seq_mult16 (WIDTH=16). Expected products come from
// plain multiplication; timing expectations come from the fixed 16-cycle
// latency. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_seq_mult16;

  localparam int W   = 16;
  localparam int LAT = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int n_checks;
  int n_err;
  logic [31:0] model_prod;

  seq_mult16 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a start for one edge, then scramble the operand inputs so that
  // any resampling would corrupt the result. Returns at the sample point
  // right after the accepting edge.
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb);
    start = 1'b1;
    a     = va;
    b     = vb;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Follows an operation from the sample point after its accepting edge to
  // the done cycle. Optionally pulses an extra start at cycle inj_at.
  task automatic finish_op(input string tag, input logic [W-1:0] va,
                           input logic [W-1:0] vb, input int inj_at);
    logic [31:0] exp;
    exp = 32'(va) * 32'(vb);
    for (int n = 0; n < LAT; n++) begin
      chk({tag, ":busy"}, 32'(busy), 32'd1);
      chk({tag, ":nodone"}, 32'(done), 32'd0);
      chk({tag, ":hold"}, product, model_prod);
      if (n == inj_at) begin
        start = 1'b1;
        a     = 16'd2;
        b     = 16'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, ":done"}, 32'(done), 32'd1);
    chk({tag, ":busy_lo"}, 32'(busy), 32'd0);
    chk({tag, ":prod"}, product, exp);
    model_prod = exp;
  endtask

  task automatic quiet(input string tag, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      tick();
      chk({tag, ":nodone"}, 32'(done), 32'd0);
      chk({tag, ":idle"}, 32'(busy), 32'd0);
      chk({tag, ":hold"}, product, model_prod);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    n_checks   = 0;
    n_err      = 0;
    model_prod = 32'd0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:prod", product, 32'd0);

    // Start coincident with reset must be dropped
    start = 1'b1;
    a     = 16'd9;
    b     = 16'd9;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    chk("rst_start:busy", 32'(busy), 32'd0);
    quiet("rst_start", 3);

    // Basic
    start_op(16'd3, 16'd5);
    finish_op("basic", 16'd3, 16'd5, -1);
    chk("basic:val", product, 32'h0000000F);
    quiet("basic", 2);

    // Max operands
    start_op(16'hFFFF, 16'hFFFF);
    finish_op("max", 16'hFFFF, 16'hFFFF, -1);
    chk("max:val", product, 32'hFFFE0001);
    quiet("max", 2);

    // Zero operand, full latency, previous product held meanwhile
    start_op(16'h0000, 16'h1234);
    finish_op("zero", 16'h0000, 16'h1234, -1);
    quiet("zero", 2);

    // Start while busy ignored
    start_op(16'd7, 16'd9);
    finish_op("busy_start", 16'd7, 16'd9, 5);
    chk("busy_start:val", product, 32'h3F);
    quiet("busy_start", 20);

    // Back-to-back: start in the done cycle of the prior op
    start_op(16'd11, 16'd13);
    finish_op("b2b_first", 16'd11, 16'd13, -1);
    start_op(16'd100, 16'd200);
    finish_op("b2b", 16'd100, 16'd200, -1);
    chk("b2b:val", product, 32'h4E20);
    quiet("b2b", 2);

    // Reset mid-operation
    start_op(16'd10, 16'd10);
    for (int n = 0; n < 7; n++) begin
      chk("abort:busy", 32'(busy), 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_prod = 32'd0;
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:done", 32'(done), 32'd0);
    chk("abort:prod", product, 32'd0);
    quiet("abort", 20);
    start_op(16'd4, 16'd4);
    finish_op("after_abort", 16'd4, 16'd4, -1);
    chk("after_abort:val", product, 32'd16);

    // Randomised operations with random idle gaps (0 = back-to-back)
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) quiet("rand_gap", gap);
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 6 == 0) ra = '1;
      if (i % 6 == 3) rb = '0;
      start_op(ra, rb);
      finish_op("rand", ra, rb, (i % 4 == 1) ? int'($urandom_range(0, 14)) : -1);
    end
    quiet("tail", 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_seq_mult16
